// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the fetch stage.
// Provides fetch FSM state enum, instruction width, NOP and vectors.
package pc_fetch_pkg;

  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;
  localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0] TRAP_VEC_DEF = 32'h0000_0100;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: imem request/response and decode/retire bundle.
// master = fetch stage, slave = memory plus execute side.
interface pc_fetch_if;
  import pc_fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [INST_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] inst_pc;
  logic [INST_W-1:0] pc_plus4;
  logic              next_pc_src;
  logic [INST_W-1:0] target;
  logic              trap_misaligned;
  logic [INST_W-1:0] trap_addr;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    output pc_plus4,
    input  inst_ready,
    input  next_pc_src,
    input  target,
    output trap_misaligned,
    output trap_addr
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  pc_plus4,
    output inst_ready,
    output next_pc_src,
    output target,
    input  trap_misaligned,
    input  trap_addr
  );

endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC select for a retiring instruction.
// In: inst_pc, next_pc_src, target. Out: next_pc, misaligned.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic [INST_W-1:0] inst_pc,
  input  logic              next_pc_src,
  input  logic [INST_W-1:0] target,
  output logic [INST_W-1:0] next_pc,
  output logic              misaligned
);

  logic [INST_W-1:0] seq_pc;

  // wraps modulo 2^32 by width
  assign seq_pc = inst_pc + 32'd4;

  assign misaligned = next_pc_src &&
                      (target[1:0] != 2'b00);

  always_comb begin
    next_pc = seq_pc;
    unique case (1'b1)
      !next_pc_src: next_pc = seq_pc;
      misaligned:   next_pc = TRAP_VEC;
      default:      next_pc = target;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and single-outstanding instruction fetch FSM.
// Ports: clk, rst_n (async low), bus (pc_fetch_if.master).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [INST_W-1:0] TRAP_VEC = TRAP_VEC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   bus
);

  state_t            state_q;
  state_t            state_d;
  logic [INST_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic [INST_W-1:0] trap_addr_q;
  logic              trap_q;
  logic [INST_W-1:0] next_pc;
  logic              misaligned;
  logic              rsp_take;
  logic              retire;

  pc_next_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_next_sel (
    .inst_pc     (pc_q),
    .next_pc_src (bus.next_pc_src),
    .target      (bus.target),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    rsp_take = 1'b0;
    retire   = 1'b0;
    unique case (1'b1)
      (state_q == REQ): begin
        if (bus.imem_req_ready) state_d = WAIT;
      end
      (state_q == WAIT): begin
        if (bus.imem_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = HOLD;
        end
      end
      (state_q == HOLD): begin
        if (bus.inst_ready) begin
          retire  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      inst_q      <= NOP;
      trap_q      <= 1'b0;
      trap_addr_q <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= retire && misaligned;
      if (rsp_take) inst_q <= bus.imem_rsp_data;
      if (retire) pc_q <= next_pc;
      if (retire && misaligned) begin
        trap_addr_q <= bus.target;
      end
    end
  end

  // PC only moves at retire, so it doubles as the
  // address of the held instruction.
  assign bus.imem_req_valid  = rst_n && (state_q == REQ);
  assign bus.imem_addr       = pc_q;
  assign bus.inst_valid      = (state_q == HOLD);
  assign bus.inst            = inst_q;
  assign bus.inst_pc         = pc_q;
  assign bus.pc_plus4        = pc_q + 32'd4;
  assign bus.trap_misaligned = trap_q;
  assign bus.trap_addr       = trap_addr_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: randomized scoreboard bench for pc_fetch.
// Drives memory/retire side; a monitor checks against a PC model.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP   = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_inst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] addr_q[$];
  exp_inst_t   inst_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] model_pc;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        p_stall_req = 1'b0;
  logic        p_hold = 1'b0;
  logic        p_mis = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_inst = '0;
  logic [31:0] p_ipc = '0;
  logic [31:0] p_p4 = '0;
  logic [31:0] p_tgt = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall_req <= 1'b0;
      p_hold      <= 1'b0;
      p_mis       <= 1'b0;
    end else begin
      if (bus.imem_req_valid && p_stall_req)
        check("req_addr_stable", bus.imem_addr, p_addr);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (addr_q.size() == 0) begin
          check("dup_req", bus.imem_addr, 32'hxxxx_xxxx);
        end else begin
          check("req_addr", bus.imem_addr, addr_q[0]);
          void'(addr_q.pop_front());
        end
      end
      if (bus.inst_valid) begin
        if (p_hold) begin
          check("inst_stable", bus.inst, p_inst);
          check("inst_pc_stable", bus.inst_pc, p_ipc);
          check("pc_plus4_stable", bus.pc_plus4, p_p4);
        end else if (inst_q.size() == 0) begin
          check("unexpected_inst", bus.inst, 32'hxxxx_xxxx);
        end else begin
          check("inst", bus.inst, inst_q[0].data);
          check("inst_pc", bus.inst_pc, inst_q[0].pc);
          check("pc_plus4", bus.pc_plus4,
                inst_q[0].pc + 32'd4);
          void'(inst_q.pop_front());
        end
      end
      if (p_mis || bus.trap_misaligned)
        check("trap_pulse", 32'(bus.trap_misaligned),
              32'(p_mis));
      if (p_mis)
        check("trap_addr", bus.trap_addr, p_tgt);
      p_stall_req <= bus.imem_req_valid && !bus.imem_req_ready;
      p_addr      <= bus.imem_addr;
      p_hold      <= bus.inst_valid && !bus.inst_ready;
      p_inst      <= bus.inst;
      p_ipc       <= bus.inst_pc;
      p_p4        <= bus.pc_plus4;
      p_mis       <= bus.inst_valid && bus.inst_ready &&
                     bus.next_pc_src &&
                     (bus.target % 4 != 0);
      p_tgt       <= bus.target;
    end
  end

  task automatic check_reset();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", bus.inst, 32'h0000_0013);
    check("rst_inst_pc", bus.inst_pc, RST_PC);
    check("rst_pc_plus4", bus.pc_plus4, RST_PC + 32'd4);
    check("rst_trap", 32'(bus.trap_misaligned), 32'd0);
    check("rst_trap_addr", bus.trap_addr, 32'd0);
  endtask

  task automatic fetch(input int rd,
                       input int wd,
                       input int hd,
                       input logic src,
                       input logic [31:0] tgt,
                       input logic [31:0] data);
    exp_inst_t e;
    addr_q.push_back(model_pc);
    check("req_present", 32'(bus.imem_req_valid), 32'd1);
    repeat (rd) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rsp_data  = $urandom;
      tick();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    check("req_drop", 32'(bus.imem_req_valid), 32'd0);
    repeat (wd) tick();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = data;
    e.data = data;
    e.pc   = model_pc;
    inst_q.push_back(e);
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("rsp_to_valid", 32'(bus.inst_valid), 32'd1);
    repeat (hd) begin
      bus.inst_ready     = 1'b0;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rsp_data  = $urandom;
      bus.next_pc_src    = 1'($urandom_range(0, 1));
      bus.target         = $urandom;
      tick();
    end
    bus.imem_rsp_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    bus.next_pc_src    = src;
    bus.target         = tgt;
    tick();
    bus.inst_ready  = 1'b0;
    bus.next_pc_src = 1'($urandom_range(0, 1));
    bus.target      = $urandom;
    if (!src) model_pc = model_pc + 32'd4;
    else if (tgt % 4 != 0) model_pc = TRAP;
    else model_pc = tgt;
  endtask

  initial begin
    logic [31:0] t;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.inst_ready     = 1'b0;
    bus.next_pc_src    = 1'b0;
    bus.target         = '0;
    model_pc = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst_n = 1'b1;
    #1;
    check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("first_req_addr", bus.imem_addr, RST_PC);

    fetch(0, 0, 0, 1'b0, 32'h0, 32'h0000_0013);
    repeat (3) fetch(0, 0, 0, 1'b0, $urandom, $urandom);
    fetch(0, 0, 0, 1'b1, 32'h40, $urandom);
    fetch(0, 0, 0, 1'b1, 32'h80, $urandom);
    fetch(0, 0, 0, 1'b1, 32'h82, $urandom);
    fetch(5, 0, 0, 1'b0, 32'h0, $urandom);
    fetch(0, 7, 0, 1'b0, 32'h0, $urandom);
    fetch(0, 0, 4, 1'b0, 32'h0, $urandom);
    fetch(0, 0, 0, 1'b1, 32'hFFFF_FFFC, $urandom);
    fetch(0, 0, 0, 1'b0, 32'h0, $urandom);
    fetch(1, 0, 0, 1'b0, 32'h0, $urandom);

    for (int i = 0; i < 40; i++) begin
      t = $urandom;
      if ($urandom_range(0, 2) != 0) t = t & 32'hFFFF_FFFC;
      fetch($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            t, $urandom);
    end

    addr_q.push_back(model_pc);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_reset();
    addr_q.delete();
    inst_q.delete();
    model_pc = RST_PC;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_rsp_valid = 1'b0;
    check("abort_no_valid", 32'(bus.inst_valid), 32'd0);
    fetch(0, 0, 0, 1'b0, 32'h0, 32'h1234_5678);
    fetch(2, 1, 1, 1'b0, 32'h0, $urandom);
    fetch(0, 0, 0, 1'b1, 32'h0000_0203, $urandom);
    fetch(0, 0, 0, 1'b0, 32'h0, $urandom);

    repeat (3) tick();
    check("leftover_exp", 32'(addr_q.size() + inst_q.size()),
          32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
